// File: rtl/msb_pkg.sv
// Shared constants for the MSB/LSB finder: leaf group geometry and group count helper.
package msb_pkg;

    localparam int GROUP_W    = 8;
    localparam int GROUP_SIZE = 3;

    function automatic int group_count(input int size);
        return (1 << size) / GROUP_W;
    endfunction

endpackage

// File: rtl/msb8_enc.sv
// Combinational 8-bit leaf encoder: reports whether the byte has a set bit and the
// index of its highest (lsb_mode = 0) or lowest (lsb_mode = 1) set bit.
module msb8_enc
    import msb_pkg::*;
(
    input  logic [GROUP_W-1:0]    byte_in,
    input  logic                  lsb_mode,
    output logic                  found,
    output logic [GROUP_SIZE-1:0] idx
);

    // Scan order decides the winner: the last set bit visited is the one reported.
    always_comb begin
        found = |byte_in;
        idx   = '0;
        if (lsb_mode) begin
            for (int i = GROUP_W - 1; i >= 0; i--) begin
                if (byte_in[i]) idx = GROUP_SIZE'(i);
            end
        end else begin
            for (int i = 0; i < GROUP_W; i++) begin
                if (byte_in[i]) idx = GROUP_SIZE'(i);
            end
        end
    end

endmodule

// File: rtl/msb_finder_pipe.sv
// Two-stage set-bit finder: stage 1 registers per-byte leaf results, stage 2 picks
// the winning byte and registers pos = {group index, in-group index} and found.
module msb_finder_pipe
    import msb_pkg::*;
#(
    parameter int SIZE  = 6,
    parameter int DW_IN = 2 ** SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW_IN-1:0] data,
    input  logic             lsb_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  pos,
    output logic             found
);

    localparam int NG = group_count(SIZE);
    localparam int GW = (SIZE > GROUP_SIZE) ? SIZE - GROUP_SIZE : 1;

    // Handshake: a beat moves on a rising edge where valid && ready; the whole pipe
    // advances together when the output slot is empty or being drained, so
    // in_ready = !out_valid || out_ready, and everything holds otherwise.
    logic enable;
    assign enable   = !out_valid || out_ready;
    assign in_ready = enable;

    logic [NG-1:0]                 enc_found;
    logic [NG-1:0][GROUP_SIZE-1:0] enc_idx;

    for (genvar g = 0; g < NG; g++) begin : g_enc
        msb8_enc u_enc (
            .byte_in  (data[g*GROUP_W +: GROUP_W]),
            .lsb_mode (lsb_mode),
            .found    (enc_found[g]),
            .idx      (enc_idx[g])
        );
    end

    logic                          s1_valid;
    logic                          s1_lsb;
    logic [NG-1:0]                 s1_found;
    logic [NG-1:0][GROUP_SIZE-1:0] s1_idx;

    logic                  c_found;
    logic [GW-1:0]         c_grp;
    logic [GROUP_SIZE-1:0] c_idx;
    logic [SIZE-1:0]       pos_next;

    // msb mode keeps the highest group that found a bit; lsb mode keeps the first.
    always_comb begin
        c_found = 1'b0;
        c_grp   = '0;
        c_idx   = '0;
        for (int g = 0; g < NG; g++) begin
            if (s1_found[g] && (!s1_lsb || !c_found)) begin
                c_found = 1'b1;
                c_grp   = GW'(g);
                c_idx   = s1_idx[g];
            end
        end
    end

    if (NG == 1) begin : g_single
        assign pos_next = c_idx;
    end else begin : g_multi
        assign pos_next = {c_grp, c_idx};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_lsb    <= 1'b0;
            s1_found  <= '0;
            s1_idx    <= '0;
            out_valid <= 1'b0;
            pos       <= '0;
            found     <= 1'b0;
        end else if (enable) begin
            s1_valid  <= in_valid;
            s1_lsb    <= lsb_mode;
            s1_found  <= enc_found;
            s1_idx    <= enc_idx;
            out_valid <= s1_valid;
            pos       <= pos_next;
            found     <= c_found;
        end
    end

endmodule

// File: tb/tb_msb_finder_pipe.sv
// Bench for msb_finder_pipe: directed vectors with hand-computed results, an in-order
// scoreboard on the output handshake, and a SIZE = 3 instance for the single-group case.
module tb_msb_finder_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] data = '0;
    logic        lsb_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [5:0]  pos;
    logic        found;

    logic        s3_in_valid = 1'b0;
    logic        s3_in_ready;
    logic [7:0]  s3_data = '0;
    logic        s3_lsb_mode = 1'b0;
    logic        s3_out_valid;
    logic        s3_out_ready = 1'b1;
    logic [2:0]  s3_pos;
    logic        s3_found;

    int checks = 0;
    int failures = 0;
    int acc_cnt = 0;
    int streak = 0;
    int peak_streak = 0;
    bit stall_prev = 0;
    bit rnd_done = 0;
    logic [6:0] held;
    logic [6:0] e;
    logic [6:0] exp_q[$];

    logic [63:0] vd[10];
    logic [5:0]  vmsb[10];
    logic [5:0]  vlsb[10];
    logic        vf[10];

    msb_finder_pipe #(.SIZE(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .lsb_mode  (lsb_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pos       (pos),
        .found     (found)
    );

    msb_finder_pipe #(.SIZE(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s3_in_valid),
        .in_ready  (s3_in_ready),
        .data      (s3_data),
        .lsb_mode  (s3_lsb_mode),
        .out_valid (s3_out_valid),
        .out_ready (s3_out_ready),
        .pos       (s3_pos),
        .found     (s3_found)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard / monitor on the output handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
            streak = 0;
        end else begin
            if (stall_prev) begin
                check_eq("hold_valid", 64'(out_valid), 64'd1);
                check_eq("hold_data", 64'({pos, found}), 64'(held));
            end
            if (out_valid && !out_ready)
                check_eq("stall_in_ready", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("sb_pos", 64'(pos), 64'(e[6:1]));
                    check_eq("sb_found", 64'(found), 64'(e[0]));
                end
                streak++;
                if (streak > peak_streak) peak_streak = streak;
            end else begin
                streak = 0;
            end
            stall_prev = out_valid && !out_ready;
            held = {pos, found};
        end
    end

    // driver tasks
    task automatic send(input logic [63:0] d, input logic m, input logic [5:0] ep,
                        input logic ef, input bit push);
        int n = 0;
        bit ok = 0;
        in_valid = 1'b1;
        data = d;
        lsb_mode = m;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("send_accept", 64'(ok), 64'd1);
        if (ok) begin
            acc_cnt++;
            if (push) exp_q.push_back({ep, ef});
        end
        in_valid = 1'b0;
    endtask

    task automatic lat_check(input logic [63:0] d, input logic m, input logic [5:0] ep,
                             input logic ef);
        in_valid = 1'b1;
        data = d;
        lsb_mode = m;
        @(negedge clk);
        check_eq("lat_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back({ep, ef});
        @(negedge clk);
        check_eq("lat_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_eq("lat_cycle2_valid", 64'(out_valid), 64'd1);
        check_eq("lat_pos", 64'(pos), 64'(ep));
        check_eq("lat_found", 64'(found), 64'(ef));
        @(posedge clk);
        #1;
    endtask

    task automatic lat3(input logic [7:0] d, input logic m, input logic [2:0] ep, input logic ef);
        s3_in_valid = 1'b1;
        s3_data = d;
        s3_lsb_mode = m;
        @(negedge clk);
        check_eq("s3_in_ready", 64'(s3_in_ready), 64'd1);
        @(posedge clk);
        #1;
        s3_in_valid = 1'b0;
        @(negedge clk);
        check_eq("s3_cycle1_valid", 64'(s3_out_valid), 64'd0);
        @(negedge clk);
        check_eq("s3_cycle2_valid", 64'(s3_out_valid), 64'd1);
        check_eq("s3_pos", 64'(s3_pos), 64'(ep));
        check_eq("s3_found", 64'(s3_found), 64'(ef));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        vd[0] = 64'h0000_0000_0000_0080; vmsb[0] = 6'd7;  vlsb[0] = 6'd7;  vf[0] = 1'b1;
        vd[1] = 64'hFFFF_FFFF_FFFF_FFFF; vmsb[1] = 6'd63; vlsb[1] = 6'd0;  vf[1] = 1'b1;
        vd[2] = 64'h0000_0100_0000_0000; vmsb[2] = 6'd40; vlsb[2] = 6'd40; vf[2] = 1'b1;
        vd[3] = 64'h8000_0000_0000_0000; vmsb[3] = 6'd63; vlsb[3] = 6'd63; vf[3] = 1'b1;
        vd[4] = 64'h0000_0000_0000_0000; vmsb[4] = 6'd0;  vlsb[4] = 6'd0;  vf[4] = 1'b0;
        vd[5] = 64'h0000_0000_0000_0001; vmsb[5] = 6'd0;  vlsb[5] = 6'd0;  vf[5] = 1'b1;
        vd[6] = 64'h0123_4567_89AB_CDEF; vmsb[6] = 6'd56; vlsb[6] = 6'd0;  vf[6] = 1'b1;
        vd[7] = 64'h0018_0000_0000_0600; vmsb[7] = 6'd52; vlsb[7] = 6'd9;  vf[7] = 1'b1;
        vd[8] = 64'h0000_0000_0002_0000; vmsb[8] = 6'd17; vlsb[8] = 6'd17; vf[8] = 1'b1;
        vd[9] = 64'h4000_0000_8000_0000; vmsb[9] = 6'd62; vlsb[9] = 6'd31; vf[9] = 1'b1;

        // reset with beats offered: they must be ignored
        rst_n = 1'b0;
        in_valid = 1'b1;
        data = 64'hFFFF;
        s3_in_valid = 1'b1;
        s3_data = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        s3_in_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_pos", 64'(pos), 64'd0);
        check_eq("rst_found", 64'(found), 64'd0);
        check_eq("rst_s3_out_valid", 64'(s3_out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_no_leak", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // latency and both modes on the same word
        lat_check(64'h8000_0000_0000_0001, 1'b0, 6'd63, 1'b1);
        lat_check(64'h8000_0000_0000_0001, 1'b1, 6'd0, 1'b1);
        lat_check(64'h0, 1'b0, 6'd0, 1'b0);

        // back-to-back beats with mixed modes
        peak_streak = 0;
        send(64'h0000_0000_0001_0000, 1'b0, 6'd16, 1'b1, 1);
        send(64'h0000_0000_0000_0000, 1'b0, 6'd0, 1'b0, 1);
        send(64'h00F0_0000_0000_0000, 1'b1, 6'd52, 1'b1, 1);
        drain();
        check_eq("b2b_consecutive", 64'(peak_streak), 64'd3);

        // back-pressure: out_ready low for 5 cycles with 4 beats offered
        acc_cnt = 0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(vd[i], 1'b0, vmsb[i], vf[i], 1);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check_eq("bp_accepted", 64'(acc_cnt), 64'd2);
                check_eq("bp_in_ready", 64'(in_ready), 64'd0);
                check_eq("bp_out_valid", 64'(out_valid), 64'd1);
                out_ready = 1'b1;
            end
        join
        drain();
        check_eq("bp_total", 64'(acc_cnt), 64'd4);

        // reset with two beats in flight: both discarded
        out_ready = 1'b0;
        send(vd[6], 1'b0, vmsb[6], vf[6], 0);
        send(vd[7], 1'b1, vlsb[7], vf[7], 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check_eq("midrst_no_out", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        lat_check(64'h4, 1'b0, 6'd2, 1'b1);

        // table vectors with random gaps, modes and downstream stalls
        fork
            begin
                for (int p = 0; p < 3; p++) begin
                    for (int i = 0; i < 10; i++) begin
                        int gap;
                        logic m;
                        gap = $urandom_range(0, 2);
                        m = 1'($urandom_range(0, 1));
                        if (gap > 0) begin
                            repeat (gap) @(posedge clk);
                            #1;
                        end
                        send(vd[i], m, m ? vlsb[i] : vmsb[i], vf[i], 1);
                    end
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // single-group instance
        lat3(8'b0010_1000, 1'b0, 3'd5, 1'b1);
        lat3(8'b0010_1000, 1'b1, 3'd3, 1'b1);
        lat3(8'b0000_0000, 1'b0, 3'd0, 1'b0);

        repeat (3) @(posedge clk);
        check_eq("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msb_finder_pipe.md
MSB_FINDER_PIPE -- requirements
Module: msb_finder_pipe

Interface
REQ-001 Parameter SIZE, default 6, SHALL set the log2 of the input word width; legal range 3..8.
REQ-002 Parameter DW_IN, default 2**SIZE, SHALL be the input word width and SHALL NOT be overridden independently of SIZE.
REQ-003 Port clk input 1 SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n input 1 SHALL be the reset: synchronous, active-low.
REQ-005 Port in_valid input 1 SHALL qualify data and lsb_mode.
REQ-006 Port in_ready output 1 SHALL indicate the block accepts a beat this cycle.
REQ-007 Port data input DW_IN SHALL be the word to search.
REQ-008 Port lsb_mode input 1 SHALL select per-beat search: 0 = highest set bit, 1 = lowest set bit.
REQ-009 Port out_valid output 1 SHALL qualify pos and found.
REQ-010 Port out_ready input 1 SHALL be downstream acceptance.
REQ-011 Port pos output SIZE SHALL be the bit index of the selected set bit.
REQ-012 Port found output 1 SHALL be 1 when the beat's data held at least one set bit.

Function
REQ-013 A beat SHALL transfer in when in_valid && in_ready and out when out_valid && out_ready.
REQ-014 The datapath SHALL be a two-stage pipeline. Stage 1 registers, per 8-bit group, a group-found bit and a 3-bit in-group index. Stage 2 combines groups and registers pos/found.
REQ-015 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no back-pressure; throughput SHALL be one beat per cycle.
REQ-016 The pipeline SHALL advance only when enable = !out_valid || out_ready; in_ready SHALL equal enable, combinationally; there is no bubble collapsing beyond that.
REQ-017 When enable is 0, all stage registers, out_valid, pos and found SHALL hold.
REQ-018 Stage valid bits SHALL propagate with data; a stage loaded with no input beat SHALL carry valid = 0.
REQ-019 lsb_mode SHALL travel with its beat through both stages; beats of different modes back-to-back SHALL each use their own mode.
REQ-020 msb mode: pos SHALL be the highest index i with data[i] = 1. lsb mode: pos SHALL be the lowest such index.
REQ-021 data = 0 SHALL give found = 0 and pos = 0 with out_valid = 1 (the beat is not dropped).
REQ-022 pos SHALL be formed as {group index, in-group index}; no arithmetic overflow is possible since pos is SIZE bits.
REQ-023 SIZE = 3 SHALL degenerate to one group with stage 2 a pass-through register; latency stays 2.

Reset
REQ-024 While rst_n = 0 at a clk edge, all stage valid bits and out_valid SHALL clear; pos, found and stage data SHALL clear to 0.
REQ-025 Reset mid-stream SHALL discard in-flight beats with no output; in_ready SHALL be 1 on the first cycle after reset releases.
REQ-026 During reset, in_ready SHALL read 1 (out_valid = 0); beats presented during reset SHALL be ignored.

Structure
REQ-027 Package msb_pkg SHALL hold GROUP_W = 8, GROUP_SIZE = 3 and a function computing group count from SIZE.
REQ-028 Sub-module msb8_enc SHALL be the combinational 8-bit leaf encoder (inputs: byte, lsb_mode; outputs: found, 3-bit index), instantiated DW_IN/8 times via generate.
REQ-029 All registers SHALL live in msb_finder_pipe; msb8_enc SHALL contain no state.

Verification (SIZE = 6)
REQ-030 Input data = 64'h8000_0000_0000_0001, msb mode -> two cycles later out_valid = 1, pos = 63, found = 1. The same data in lsb mode -> pos = 0.
REQ-031 Three back-to-back beats: data 64'h0000_0000_0001_0000 (msb), then 64'h0 (msb), then 64'h00F0_0000_0000_0000 (lsb) -> consecutive outputs pos/found = 16/1, 0/0, 52/1 on three consecutive cycles.
REQ-032 Hold out_ready = 0 for 5 cycles with 4 beats offered -> exactly 2 beats accepted, in_ready = 0 while the output is full, outputs stable. Releasing out_ready -> remaining beats delivered in order, none lost or duplicated.
REQ-033 Assert rst_n = 0 for 1 cycle with 2 beats in flight -> no out_valid afterwards for those beats; a new beat of 64'h4 yields pos = 2 at latency 2.
REQ-034 Random regression: 10k beats with random data, mode, in_valid and out_ready -> each output matches a reference scan model in order.
REQ-035 SIZE = 3: data = 8'b0010_1000 -> msb mode pos = 5, lsb mode pos = 3, latency 2.
